uart_rx_buffered: RTL and testbench

Parametrised UART receiver with a configurable frame format, per-frame error flags, break detection and an on-chip receive FIFO. It sits between the asynchronous serial pin and the bus-side consumer. Several frames can queue, so the consumer does not have to service each byte within one character time. Errors are reported with each byte instead of the frame being silently dropped.

---
 rtl/uart_rx_buffered_pkg.sv | 31 +++
 rtl/uart_rx_buffered_if.sv | 27 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_rx_buffered.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encodings, frame-format
// helpers and the receive-FIFO entry layout.
package uart_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RECEIVE   = 2'd1;
  localparam logic [1:0] ST_PUSH      = 2'd2;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  localparam int ENTRY_WIDTH   = 11;
  localparam int ENTRY_BREAK   = 10;
  localparam int ENTRY_FRAMING = 9;
  localparam int ENTRY_PARITY  = 8;

  function automatic logic [3:0] data_bit_count(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  // Total bit periods in a frame: start + data + optional parity + 1 or 2 stop.
  function automatic logic [3:0] frame_bit_count(input logic [1:0] code,
                                                 input logic       parity_en,
                                                 input logic       two_stop);
    return 4'd2 + data_bit_count(code) + {3'b000, parity_en} + {3'b000, two_stop};
  endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Bus-side port bundle of the buffered UART receiver: FIFO head, handshake and
// overrun status.
interface uart_rx_buffered_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic [7:0]               data_o;
  logic                     parity_error_o;
  logic                     framing_error_o;
  logic                     break_o;
  logic                     valid_o;
  logic                     ack_i;
  logic [FIFO_DEPTH_LOG2:0] fifo_level_o;
  logic                     overrun_o;
  logic                     clear_overrun_i;

  modport master (
    output data_o, parity_error_o, framing_error_o, break_o, valid_o,
    output fifo_level_o, overrun_o,
    input  ack_i, clear_overrun_i
  );

  modport slave (
    input  data_o, parity_error_o, framing_error_o, break_o, valid_o,
    input  fifo_level_o, overrun_o,
    output ack_i, clear_overrun_i
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word fall-through FIFO; the head entry is presented
// combinationally whenever the FIFO is non-empty and reads 0 when empty.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                wr_en;
  logic                rd_en;

  always_comb begin
    level_o  = wr_ptr_q - rd_ptr_q;
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
               (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    rd_en    = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    wr_en    = push_i && (!full_o || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head_o   = empty_o ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with per-frame format latching, parity/framing/break flags and a
// receive FIFO so several frames can queue ahead of the consumer.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDER_WIDTH = 16,
  parameter int FIFO_DEPTH_LOG2     = 4
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           serial_i,
  input  logic [1:0]                     data_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic                           stop_bits_i,
  uart_rx_buffered_if.master             bus
);
  localparam logic [CLOCK_DIVIDER_WIDTH-1:0] DIV_ONE = CLOCK_DIVIDER_WIDTH'(1);
  localparam logic [CLOCK_DIVIDER_WIDTH-1:0] DIV_TWO = CLOCK_DIVIDER_WIDTH'(2);

  logic                           sync1_q, rx_sync_q, rx_prev_q;
  logic [1:0]                     state_q, state_d;
  logic [CLOCK_DIVIDER_WIDTH-1:0] bit_timer_q, bit_timer_d;
  logic [CLOCK_DIVIDER_WIDTH-1:0] div_q, div_d;
  logic [3:0]                     bit_idx_q, bit_idx_d;
  logic [1:0]                     data_bits_q, data_bits_d;
  logic                           parity_en_q, parity_en_d;
  logic                           parity_even_q, parity_even_d;
  logic                           stop2_q, stop2_d;
  logic [7:0]                     data_q, data_d;
  logic                           parity_acc_q, parity_acc_d;
  logic                           all_zero_q, all_zero_d;
  logic                           framing_q, framing_d;
  logic                           last_stop_q, last_stop_d;
  logic                           overrun_q, overrun_d;

  logic [3:0]                     n_data, n_frame;
  logic [2:0]                     data_pos;
  logic                           sample, push, parity_err;
  logic [ENTRY_WIDTH-1:0]         push_word, head_word;
  logic                           fifo_full, fifo_empty;
  logic [FIFO_DEPTH_LOG2:0]       fifo_level;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= serial_i;
      rx_sync_q <= sync1_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    n_data     = data_bit_count(data_bits_q);
    n_frame    = frame_bit_count(data_bits_q, parity_en_q, stop2_q);
    data_pos   = 3'(bit_idx_q - 4'd1);
    sample     = (bit_timer_q == (div_q >> 1));
    parity_err = parity_en_q & (parity_even_q ? parity_acc_q : ~parity_acc_q);

    push_word                = '0;
    push_word[7:0]           = data_q;
    push_word[ENTRY_PARITY]  = parity_err;
    push_word[ENTRY_FRAMING] = framing_q;
    push_word[ENTRY_BREAK]   = all_zero_q;

    state_d       = state_q;
    bit_timer_d   = bit_timer_q;
    div_d         = div_q;
    bit_idx_d     = bit_idx_q;
    data_bits_d   = data_bits_q;
    parity_en_d   = parity_en_q;
    parity_even_d = parity_even_q;
    stop2_d       = stop2_q;
    data_d        = data_q;
    parity_acc_d  = parity_acc_q;
    all_zero_d    = all_zero_q;
    framing_d     = framing_q;
    last_stop_d   = last_stop_q;
    push          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q && (clock_divider_i >= DIV_TWO)) begin
          state_d       = ST_RECEIVE;
          div_d         = clock_divider_i;
          bit_timer_d   = clock_divider_i - DIV_ONE;
          data_bits_d   = data_bits_i;
          parity_en_d   = parity_bit_i;
          parity_even_d = parity_even_i;
          stop2_d       = stop_bits_i;
          bit_idx_d     = 4'd0;
          data_d        = 8'h00;
          parity_acc_d  = 1'b0;
          all_zero_d    = 1'b1;
          framing_d     = 1'b0;
        end
      end
      ST_RECEIVE: begin
        bit_timer_d = (bit_timer_q == '0) ? div_q - DIV_ONE : bit_timer_q - DIV_ONE;
        if (sample) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (rx_sync_q && (bit_idx_q != 4'd0)) begin
            all_zero_d = 1'b0;
          end
          if (bit_idx_q == 4'd0) begin
            // A start bit that is high at its mid-point was a glitch.
            if (rx_sync_q) begin
              state_d = ST_IDLE;
            end
          end else if (bit_idx_q <= n_data) begin
            data_d[data_pos] = rx_sync_q;
            parity_acc_d     = parity_acc_q ^ rx_sync_q;
          end else if (parity_en_q && (bit_idx_q == n_data + 4'd1)) begin
            parity_acc_d = parity_acc_q ^ rx_sync_q;
          end else begin
            last_stop_d = rx_sync_q;
            if (!rx_sync_q) begin
              framing_d = 1'b1;
            end
          end
          if (bit_idx_q == n_frame - 4'd1) begin
            state_d = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = last_stop_q ? ST_IDLE : ST_WAIT_IDLE;
      end
      default: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Setting wins over clearing so a loss in the clear cycle is not hidden.
  assign overrun_d = (push && fifo_full && !bus.ack_i) || (overrun_q && !bus.clear_overrun_i);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      bit_timer_q   <= '0;
      div_q         <= '0;
      bit_idx_q     <= 4'd0;
      data_bits_q   <= 2'd0;
      parity_en_q   <= 1'b0;
      parity_even_q <= 1'b0;
      stop2_q       <= 1'b0;
      data_q        <= 8'h00;
      parity_acc_q  <= 1'b0;
      all_zero_q    <= 1'b0;
      framing_q     <= 1'b0;
      last_stop_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_timer_q   <= bit_timer_d;
      div_q         <= div_d;
      bit_idx_q     <= bit_idx_d;
      data_bits_q   <= data_bits_d;
      parity_en_q   <= parity_en_d;
      parity_even_q <= parity_even_d;
      stop2_q       <= stop2_d;
      data_q        <= data_d;
      parity_acc_q  <= parity_acc_d;
      all_zero_q    <= all_zero_d;
      framing_q     <= framing_d;
      last_stop_q   <= last_stop_d;
      overrun_q     <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH      (ENTRY_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (bus.ack_i),
    .head_o      (head_word),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.data_o          = head_word[7:0];
  assign bus.parity_error_o  = head_word[ENTRY_PARITY];
  assign bus.framing_error_o = head_word[ENTRY_FRAMING];
  assign bus.break_o         = head_word[ENTRY_BREAK];
  assign bus.valid_o         = !fifo_empty;
  assign bus.fifo_level_o    = fifo_level;
  assign bus.overrun_o       = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed scenarios plus randomized
// frames compared against a queue-based model of the received entries.
module tb_uart_rx_buffered;
  localparam int DIV_W      = 16;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic       brk;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } entry_t;

  logic             clock_i         = 1'b0;
  logic             reset_i         = 1'b1;
  logic [DIV_W-1:0] clock_divider_i = 16'd4;
  logic             serial_i        = 1'b1;
  logic [1:0]       data_bits_i     = 2'd3;
  logic             parity_bit_i    = 1'b0;
  logic             parity_even_i   = 1'b0;
  logic             stop_bits_i     = 1'b0;

  int     checks = 0;
  int     errors = 0;
  entry_t exp_q[$];
  logic   model_overrun = 1'b0;

  always #5 clock_i = ~clock_i;

  uart_rx_buffered_if #(.FIFO_DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_rx_buffered #(
    .CLOCK_DIVIDER_WIDTH (DIV_W),
    .FIFO_DEPTH_LOG2     (DEPTH_LOG2)
  ) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .clock_divider_i (clock_divider_i),
    .serial_i        (serial_i),
    .data_bits_i     (data_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .stop_bits_i     (stop_bits_i),
    .bus             (bus)
  );

  function automatic entry_t observed();
    return {bus.break_o, bus.framing_error_o, bus.parity_error_o, bus.data_o};
  endfunction

  task automatic hold(input logic b, input int cycles);
    serial_i = b;
    repeat (cycles) @(negedge clock_i);
  endtask

  task automatic set_config(input int div, input logic [1:0] code, input logic par,
                            input logic even, input logic stop2);
    clock_divider_i = DIV_W'(div);
    data_bits_i     = code;
    parity_bit_i    = par;
    parity_even_i   = even;
    stop_bits_i     = stop2;
  endtask

  // Drives one frame with the current configuration and records what a correct
  // receiver must store for it.
  task automatic send_frame(input logic [7:0] data, input logic bad_par, input int gap);
    int         nd;
    int         div;
    logic [7:0] mask;
    logic [7:0] d;
    logic       pbit;
    entry_t     e;
    nd   = 5 + int'(data_bits_i);
    div  = int'(clock_divider_i);
    mask = 8'hFF >> (8 - nd);
    d    = data & mask;
    hold(1'b0, div);
    for (int i = 0; i < nd; i++) hold(d[i], div);
    if (parity_bit_i) begin
      pbit = parity_even_i ? (^d) : ~(^d);
      hold(pbit ^ bad_par, div);
    end
    hold(1'b1, div);
    if (stop_bits_i) hold(1'b1, div);
    e.brk  = 1'b0;
    e.fe   = 1'b0;
    e.pe   = parity_bit_i & bad_par;
    e.data = d;
    if (exp_q.size() == DEPTH) model_overrun = 1'b1;
    else exp_q.push_back(e);
    hold(1'b1, gap);
  endtask

  task automatic pop_entry(output entry_t e, output bit got);
    got = 1'b0;
    e   = '0;
    for (int i = 0; i < 300 && !bus.valid_o; i++) @(negedge clock_i);
    if (bus.valid_o) begin
      got        = 1'b1;
      e          = observed();
      bus.ack_i  = 1'b1;
      @(negedge clock_i);
      bus.ack_i  = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clock_i);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
    checks++;
    if (observed() !== 11'h000) begin errors++; $display("FAIL reset_head: got %h expected 000", observed()); end
    checks++;
    if (bus.fifo_level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.fifo_level_o); end
    checks++;
    if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun_o); end
    reset_i = 1'b0;
    repeat (6) @(negedge clock_i);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", bus.valid_o); end
    $display("test_reset done");
  endtask

  task automatic test_basic_8n1();
    set_config(4, 2'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 4);
    repeat (4) @(negedge clock_i);
    checks++;
    if (bus.fifo_level_o !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d expected 1", bus.fifo_level_o); end
    checks++;
    if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.valid_o); end
    checks++;
    if (observed() !== 11'h0A5) begin errors++; $display("FAIL basic_entry: got %h expected 0a5", observed()); end
    bus.ack_i = 1'b1;
    @(negedge clock_i);
    bus.ack_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b expected 0", bus.valid_o); end
    // Acknowledging an empty FIFO must not disturb its level.
    bus.ack_i = 1'b1;
    repeat (2) @(negedge clock_i);
    bus.ack_i = 1'b0;
    checks++;
    if (bus.fifo_level_o !== 3'd0) begin errors++; $display("FAIL empty_pop_level: got %0d expected 0", bus.fifo_level_o); end
    exp_q.delete();
    $display("test_basic_8n1 done");
  endtask

  task automatic test_parity_7e2();
    entry_t e;
    bit     got;
    set_config(4, 2'd2, 1'b1, 1'b1, 1'b1);
    send_frame(8'h41, 1'b1, 4);
    pop_entry(e, got);
    checks++;
    if (!got) begin errors++; $display("FAIL parity_timeout: got no entry expected one"); end
    checks++;
    if (e !== 11'h141) begin errors++; $display("FAIL parity_entry: got %h expected 141", e); end
    exp_q.delete();
    $display("test_parity_7e2 entry=%h", e);
  endtask

  task automatic test_break();
    entry_t e;
    bit     got;
    set_config(4, 2'd3, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 80);
    hold(1'b1, 40);
    checks++;
    if (bus.fifo_level_o !== 3'd1) begin errors++; $display("FAIL break_level: got %0d expected 1", bus.fifo_level_o); end
    pop_entry(e, got);
    checks++;
    if (!got || e !== 11'h600) begin errors++; $display("FAIL break_entry: got %h expected 600", e); end
    repeat (8) @(negedge clock_i);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL break_phantom: got %b expected 0", bus.valid_o); end
    send_frame(8'h5A, 1'b0, 4);
    pop_entry(e, got);
    checks++;
    if (!got || e !== 11'h05A) begin errors++; $display("FAIL break_recover: got %h expected 05a", e); end
    exp_q.delete();
    $display("test_break done");
  endtask

  task automatic test_glitch();
    entry_t e;
    bit     got;
    set_config(8, 2'd3, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 3);
    hold(1'b1, 64);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.fifo_level_o !== 3'd0) begin
      errors++; $display("FAIL glitch_entry: got level %0d expected 0", bus.fifo_level_o);
    end
    send_frame(8'hC3, 1'b0, 8);
    pop_entry(e, got);
    checks++;
    if (!got || e !== 11'h0C3) begin errors++; $display("FAIL glitch_recover: got %h expected 0c3", e); end
    exp_q.delete();
    $display("test_glitch done");
  endtask

  task automatic test_overrun();
    entry_t e;
    bit     got;
    set_config(4, 2'd3, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    model_overrun = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 2);
    hold(1'b1, 8);
    checks++;
    if (int'(bus.fifo_level_o) != exp_q.size()) begin
      errors++; $display("FAIL overrun_level: got %0d expected %0d", bus.fifo_level_o, exp_q.size());
    end
    checks++;
    if (bus.data_o !== exp_q[0].data) begin errors++; $display("FAIL overrun_head: got %h expected %h", bus.data_o, exp_q[0].data); end
    checks++;
    if (bus.overrun_o !== model_overrun) begin errors++; $display("FAIL overrun_flag: got %b expected %b", bus.overrun_o, model_overrun); end
    bus.clear_overrun_i = 1'b1;
    @(negedge clock_i);
    bus.clear_overrun_i = 1'b0;
    model_overrun = 1'b0;
    checks++;
    if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", bus.overrun_o); end
    while (exp_q.size() > 0) begin
      pop_entry(e, got);
      checks++;
      if (!got || e !== exp_q[0]) begin errors++; $display("FAIL overrun_drain: got %h expected %h", e, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    $display("test_overrun done");
  endtask

  task automatic test_back_to_back();
    entry_t e;
    bit     got;
    set_config(5, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 0);
    hold(1'b1, 10);
    checks++;
    if (int'(bus.fifo_level_o) != exp_q.size()) begin
      errors++; $display("FAIL b2b_level: got %0d expected %0d", bus.fifo_level_o, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      pop_entry(e, got);
      checks++;
      if (!got || e !== exp_q[0]) begin errors++; $display("FAIL b2b_entry: got %h expected %h", e, exp_q[0]); end
      $display("b2b entry got=%h exp=%h", e, exp_q[0]);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_midframe();
    entry_t e;
    bit     got;
    set_config(4, 2'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 4);
    hold(1'b0, 4);
    for (int i = 0; i < 3; i++) hold(1'b1, 4);
    hold(1'b1, 2);
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    checks++;
    if ({bus.valid_o, bus.overrun_o, observed(), bus.fifo_level_o} !== 16'h0000) begin
      errors++; $display("FAIL midreset_outputs: got valid %b head %h level %0d expected all 0",
                         bus.valid_o, observed(), bus.fifo_level_o);
    end
    reset_i = 1'b0;
    model_overrun = 1'b0;
    hold(1'b1, 40);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL midreset_partial: got %b expected 0", bus.valid_o); end
    exp_q.delete();
    send_frame(8'h3C, 1'b0, 4);
    pop_entry(e, got);
    checks++;
    if (!got || e !== 11'h03C) begin errors++; $display("FAIL midreset_next: got %h expected 03c", e); end
    exp_q.delete();
    $display("test_reset_midframe done");
  endtask

  task automatic test_random();
    entry_t e;
    bit     got;
    int     n;
    exp_q.delete();
    for (int it = 0; it < 15; it++) begin
      n = $urandom_range(1, 3);
      for (int f = 0; f < n; f++) begin
        set_config($urandom_range(4, 9), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 3));
      end
      hold(1'b1, 6);
      while (exp_q.size() > 0) begin
        pop_entry(e, got);
        checks++;
        if (!got || e !== exp_q[0]) begin errors++; $display("FAIL random_entry: got %h expected %h", e, exp_q[0]); end
        $display("random entry got=%h exp=%h", e, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    checks++;
    if (bus.fifo_level_o !== 3'd0 || bus.overrun_o !== model_overrun) begin
      errors++; $display("FAIL random_end: got level %0d overrun %b expected 0 %b",
                         bus.fifo_level_o, bus.overrun_o, model_overrun);
    end
  endtask

  initial begin
    bus.ack_i           = 1'b0;
    bus.clear_overrun_i = 1'b0;
    @(negedge clock_i);
    test_reset();
    test_basic_8n1();
    test_parity_7e2();
    test_break();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
